// File: rtl/ddr_line_fetch_sched.sv
// Arbitrates the shared DDR port: scanline prefetch (priority) versus host single-word writes.
// Optional FETCH_STATS_EN macro enables the saturating 16-bit overrun counter.
module ddr_line_fetch_sched #(
  parameter int              ADDR_W     = 29,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0600000,
  parameter int              LINE_WORDS = 32,
  parameter int              BURST      = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              line_start_i,
  input  logic [7:0]        line_num_i,
  input  logic              host_wr_req_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [63:0]       host_wdata_i,
  output logic              host_wr_ack_o,
  output logic [ADDR_W-1:0] ddr_addr_o,
  output logic [7:0]        ddr_burstcnt_o,
  output logic              ddr_read_o,
  output logic              ddr_write_o,
  output logic [63:0]       ddr_wdata_o,
  input  logic              ddr_busy_i,
  input  logic [63:0]       ddr_rdata_i,
  input  logic              ddr_rdata_ready_i,
  output logic              lb_we_o,
  output logic [5:0]        lb_addr_o,
  output logic [63:0]       lb_data_o,
  output logic              fetch_busy_o,
  output logic              overrun_o,
  output logic [15:0]       overrun_cnt_o
);

  localparam int NBURST = LINE_WORDS / BURST;
  localparam int BIW    = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam int CW     = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BIW-1:0] LAST_BURST = BIW'(NBURST - 1);
  localparam logic [CW-1:0]  LAST_BEAT  = CW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_CMD} state_t;

  state_t            state_q, state_d;
  logic              pend_q;
  logic [7:0]        pend_line_q, cur_line_q;
  logic [BIW-1:0]    burst_q;
  logic [CW-1:0]     beat_q;
  logic              lb_we_q, done_q, fetch_busy_q, overrun_q, ack_q;
  logic [5:0]        lb_addr_q;
  logic [63:0]       lb_data_q, wr_data_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr;
  logic              start_fetch, next_burst, fetch_done, wr_start;
  logic              pend_any, beat_last, beat_in;
  logic [7:0]        pend_line;
  logic [4:0]        lb_word;

  // A line_start in the current cycle counts as pending so it beats a simultaneous host request.
  assign pend_any  = pend_q | line_start_i;
  assign pend_line = line_start_i ? line_num_i : pend_line_q;
  assign beat_in   = (state_q == RD_DATA) && ddr_rdata_ready_i;
  assign beat_last = beat_in && (beat_q == LAST_BEAT);
  assign lb_word   = 5'((int'(burst_q) * BURST) + int'(beat_q));
  assign rd_addr   = BASE_ADDR + ADDR_W'(cur_line_q) * ADDR_W'(LINE_WORDS)
                   + ADDR_W'(burst_q) * ADDR_W'(BURST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pend_line_q  <= '0;
      cur_line_q   <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      lb_we_q      <= 1'b0;
      lb_addr_q    <= '0;
      lb_data_q    <= '0;
      done_q       <= 1'b0;
      fetch_busy_q <= 1'b0;
      overrun_q    <= 1'b0;
      ack_q        <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_fetch) begin
        cur_line_q <= pend_line;
        burst_q    <= '0;
        pend_q     <= 1'b0;
      end else begin
        if (next_burst) burst_q <= burst_q + 1'b1;
        if (line_start_i) begin
          pend_q      <= 1'b1;
          pend_line_q <= line_num_i;
        end
      end
      if (state_q == RD_CMD) beat_q <= '0;
      else if (beat_in)      beat_q <= beat_q + 1'b1;
      lb_we_q   <= beat_in;
      lb_addr_q <= {cur_line_q[0], lb_word};
      lb_data_q <= ddr_rdata_i;
      // fetch_busy drops the cycle after the final line-buffer write is presented
      done_q <= fetch_done;
      if (line_start_i)  fetch_busy_q <= 1'b1;
      else if (done_q)   fetch_busy_q <= 1'b0;
      if (line_start_i && fetch_busy_q) overrun_q <= 1'b1;
      if (wr_start) begin
        wr_addr_q <= host_addr_i;
        wr_data_q <= host_wdata_i;
      end
      ack_q <= (state_q == WR_CMD) && !ddr_busy_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_fetch = 1'b0;
    next_burst  = 1'b0;
    fetch_done  = 1'b0;
    wr_start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_any) begin
          state_d     = RD_CMD;
          start_fetch = 1'b1;
        end else if (host_wr_req_i && !ack_q) begin
          state_d  = WR_CMD;
          wr_start = 1'b1;
        end
      end
      RD_CMD:  if (!ddr_busy_i) state_d = RD_DATA;
      RD_DATA: begin
        if (beat_last) begin
          if (pend_any) begin
            state_d     = RD_CMD;
            start_fetch = 1'b1;
          end else if (burst_q != LAST_BURST) begin
            state_d    = RD_CMD;
            next_burst = 1'b1;
          end else begin
            state_d    = IDLE;
            fetch_done = 1'b1;
          end
        end
      end
      WR_CMD:  if (!ddr_busy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ddr_read_o     = 1'b0;
    ddr_write_o    = 1'b0;
    ddr_addr_o     = '0;
    ddr_burstcnt_o = '0;
    ddr_wdata_o    = '0;
    case (state_q)
      RD_CMD: begin
        ddr_read_o     = 1'b1;
        ddr_addr_o     = rd_addr;
        ddr_burstcnt_o = 8'(BURST);
      end
      WR_CMD: begin
        ddr_write_o    = 1'b1;
        ddr_addr_o     = wr_addr_q;
        ddr_burstcnt_o = 8'd1;
        ddr_wdata_o    = wr_data_q;
      end
      default: ;
    endcase
  end

  assign host_wr_ack_o = ack_q;
  assign lb_we_o       = lb_we_q;
  assign lb_addr_o     = lb_addr_q;
  assign lb_data_o     = lb_data_q;
  assign fetch_busy_o  = fetch_busy_q;
  assign overrun_o     = overrun_q;

`ifdef FETCH_STATS_EN
  logic [15:0] overrun_cnt_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) overrun_cnt_q <= '0;
    else if (line_start_i && fetch_busy_q && overrun_cnt_q != 16'hFFFF)
      overrun_cnt_q <= overrun_cnt_q + 16'd1;
  end
  assign overrun_cnt_o = overrun_cnt_q;
`else
  assign overrun_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ddr_line_fetch_sched.sv
// Directed bench for ddr_line_fetch_sched with a small DDR responder that returns
// one beat per cycle; each read beat's data encodes its DDR word address.
module tb_ddr_line_fetch_sched;
  localparam logic [28:0] BASE = 29'h0600000;

  logic        clk = 1'b0;
  logic        reset, line_start, host_wr_req, host_wr_ack;
  logic [7:0]  line_num, ddr_burstcnt;
  logic [28:0] host_addr, ddr_addr;
  logic [63:0] host_wdata, ddr_wdata, ddr_rdata, lb_data;
  logic        ddr_read, ddr_write, ddr_busy, ddr_rdata_ready, lb_we;
  logic        fetch_busy, overrun;
  logic [5:0]  lb_addr;
  logic [15:0] overrun_cnt;

  always #5 clk = ~clk;

  ddr_line_fetch_sched dut (
    .clk_i(clk), .reset_i(reset), .line_start_i(line_start), .line_num_i(line_num),
    .host_wr_req_i(host_wr_req), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_wr_ack_o(host_wr_ack), .ddr_addr_o(ddr_addr), .ddr_burstcnt_o(ddr_burstcnt),
    .ddr_read_o(ddr_read), .ddr_write_o(ddr_write), .ddr_wdata_o(ddr_wdata),
    .ddr_busy_i(ddr_busy), .ddr_rdata_i(ddr_rdata), .ddr_rdata_ready_i(ddr_rdata_ready),
    .lb_we_o(lb_we), .lb_addr_o(lb_addr), .lb_data_o(lb_data),
    .fetch_busy_o(fetch_busy), .overrun_o(overrun), .overrun_cnt_o(overrun_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [28:0] rd_addr_log[$];
  logic [7:0]  rd_bc_log[$];
  int          rd_cyc_log[$];
  logic [28:0] wr_addr_log[$];
  logic [63:0] wr_data_log[$];
  logic [7:0]  wr_bc_log[$];
  int          wr_cyc_log[$];
  logic [5:0]  we_addr_log[$];
  logic [63:0] we_data_log[$];
  int          we_cyc_log[$];
  int          ack_cyc_log[$];
  int          fb_fall_cyc;
  logic        prev_fb;
  int          beats_left = 0;
  int          beat_i = 0;
  logic [28:0] beat_addr = '0;
  logic        start_beats = 1'b0;
  int          busy_hold = 0;
  logic        ack_seen;

  function automatic logic [63:0] pat(input logic [28:0] a);
    return {32'hCAFE_0000, 3'b000, a};
  endfunction

  task automatic clear_logs();
    rd_addr_log.delete(); rd_bc_log.delete(); rd_cyc_log.delete();
    wr_addr_log.delete(); wr_data_log.delete(); wr_bc_log.delete(); wr_cyc_log.delete();
    we_addr_log.delete(); we_data_log.delete(); we_cyc_log.delete();
    ack_cyc_log.delete();
    fb_fall_cyc = -1;
    prev_fb = fetch_busy;
  endtask

  // One clock: observe at negedge, then update responder/inputs just after posedge.
  task automatic tick();
    @(negedge clk);
    ack_seen = 1'b0;
    if (ddr_read && !ddr_busy) begin
      rd_addr_log.push_back(ddr_addr); rd_bc_log.push_back(ddr_burstcnt); rd_cyc_log.push_back(cyc);
      beat_addr = ddr_addr;
      start_beats = 1'b1;
    end
    if (ddr_write && !ddr_busy) begin
      wr_addr_log.push_back(ddr_addr); wr_data_log.push_back(ddr_wdata);
      wr_bc_log.push_back(ddr_burstcnt); wr_cyc_log.push_back(cyc);
    end
    if (lb_we) begin
      we_addr_log.push_back(lb_addr); we_data_log.push_back(lb_data); we_cyc_log.push_back(cyc);
    end
    if (host_wr_ack) begin
      ack_cyc_log.push_back(cyc);
      ack_seen = 1'b1;
    end
    if (prev_fb && !fetch_busy && fb_fall_cyc < 0) fb_fall_cyc = cyc;
    prev_fb = fetch_busy;
    @(posedge clk);
    cyc++;
    #1;
    line_start = 1'b0;
    if (ack_seen) host_wr_req = 1'b0;
    if (start_beats) begin
      beats_left = 8;
      beat_i = 0;
      start_beats = 1'b0;
    end
    if (beats_left > 0) begin
      ddr_rdata_ready = 1'b1;
      ddr_rdata = pat(beat_addr + 29'(beat_i));
      beat_i++;
      beats_left--;
    end else begin
      ddr_rdata_ready = 1'b0;
    end
    if (busy_hold > 0) begin
      ddr_busy = 1'b1;
      busy_hold--;
    end else begin
      ddr_busy = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; line_start = 1'b0; line_num = '0; host_wr_req = 1'b0;
    host_addr = '0; host_wdata = '0; ddr_busy = 1'b0; ddr_rdata = '0; ddr_rdata_ready = 1'b0;
    tick(); tick();
    checks++; if (ddr_read !== 1'b0 || ddr_write !== 1'b0) begin errors++;
      $display("FAIL reset_cmd got rd=%0b wr=%0b exp 0 0", ddr_read, ddr_write); end
    checks++; if (host_wr_ack !== 1'b0 || lb_we !== 1'b0) begin errors++;
      $display("FAIL reset_ack_we got ack=%0b we=%0b exp 0 0", host_wr_ack, lb_we); end
    checks++; if (fetch_busy !== 1'b0 || overrun !== 1'b0 || overrun_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_status got fb=%0b ov=%0b cnt=%0d exp 0 0 0", fetch_busy, overrun, overrun_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_line_fetch();
    clear_logs();
    line_num = 8'd5; line_start = 1'b1;
    tick();
    checks++; if (fetch_busy !== 1'b1) begin errors++;
      $display("FAIL fetch_busy_rise got %0b exp 1", fetch_busy); end
    for (int i = 0; i < 200 && fb_fall_cyc < 0; i++) tick();
    checks++; if (fb_fall_cyc < 0) begin errors++;
      $display("FAIL line_fetch_timeout got no fetch_busy fall exp fall within 200 cycles"); end
    checks++;
    if (rd_addr_log.size() != 4) begin errors++;
      $display("FAIL line_fetch_rd_count got %0d exp 4", rd_addr_log.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_addr_log[k] !== BASE + 29'(160 + 8 * k) || rd_bc_log[k] !== 8'd8) begin errors++;
        $display("FAIL line_fetch_rd%0d got addr=%h bc=%0d exp addr=%h bc=8", k, rd_addr_log[k],
                 rd_bc_log[k], BASE + 29'(160 + 8 * k)); end
    end
    checks++;
    if (we_addr_log.size() != 32) begin errors++;
      $display("FAIL line_fetch_we_count got %0d exp 32", we_addr_log.size()); end
    else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (we_addr_log[i] !== 6'(32 + i) || we_data_log[i] !== pat(BASE + 29'(160 + i))) begin errors++;
          $display("FAIL line_fetch_we%0d got addr=%0d data=%h exp addr=%0d data=%h", i, we_addr_log[i],
                   we_data_log[i], 32 + i, pat(BASE + 29'(160 + i))); end
      end
      checks++;
      if (fb_fall_cyc != we_cyc_log[31] + 1) begin errors++;
        $display("FAIL fetch_busy_fall got cycle %0d exp %0d", fb_fall_cyc, we_cyc_log[31] + 1); end
    end
    checks++; if (wr_addr_log.size() != 0) begin errors++;
      $display("FAIL line_fetch_no_write got %0d writes exp 0", wr_addr_log.size()); end
  endtask

  task automatic test_host_write();
    clear_logs();
    host_addr = 29'h100; host_wdata = 64'hDEAD_BEEF; host_wr_req = 1'b1;
    for (int i = 0; i < 20 && ack_cyc_log.size() == 0; i++) tick();
    repeat (4) tick();
    checks++;
    if (wr_addr_log.size() != 1) begin errors++;
      $display("FAIL host_wr_count got %0d exp 1", wr_addr_log.size()); end
    else begin
      checks++;
      if (wr_addr_log[0] !== 29'h100 || wr_data_log[0] !== 64'hDEAD_BEEF || wr_bc_log[0] !== 8'd1) begin
        errors++;
        $display("FAIL host_wr_cmd got addr=%h data=%h bc=%0d exp 100 deadbeef 1",
                 wr_addr_log[0], wr_data_log[0], wr_bc_log[0]); end
      checks++;
      if (ack_cyc_log.size() != 1 || ack_cyc_log[0] != wr_cyc_log[0] + 1) begin errors++;
        $display("FAIL host_wr_ack got %0d acks first at %0d exp 1 ack at %0d", ack_cyc_log.size(),
                 (ack_cyc_log.size() > 0) ? ack_cyc_log[0] : -1, wr_cyc_log[0] + 1); end
    end
    checks++; if (we_addr_log.size() != 0 || rd_addr_log.size() != 0) begin errors++;
      $display("FAIL host_wr_no_read got we=%0d rd=%0d exp 0 0", we_addr_log.size(), rd_addr_log.size()); end
  endtask

  task automatic test_fetch_vs_host();
    clear_logs();
    line_num = 8'd7; line_start = 1'b1;
    host_addr = 29'h1234; host_wdata = 64'h0123_4567_89AB_CDEF; host_wr_req = 1'b1;
    for (int i = 0; i < 200 && ack_cyc_log.size() == 0; i++) tick();
    checks++;
    if (rd_addr_log.size() != 4 || wr_addr_log.size() != 1 || we_addr_log.size() != 32) begin errors++;
      $display("FAIL arb_counts got rd=%0d wr=%0d we=%0d exp 4 1 32", rd_addr_log.size(),
               wr_addr_log.size(), we_addr_log.size()); end
    else begin
      checks++;
      if (rd_addr_log[0] !== BASE + 29'd224 || rd_addr_log[3] !== BASE + 29'd248) begin errors++;
        $display("FAIL arb_rd_addr got %h %h exp %h %h", rd_addr_log[0], rd_addr_log[3],
                 BASE + 29'd224, BASE + 29'd248); end
      checks++;
      if (wr_cyc_log[0] <= rd_cyc_log[3] || wr_addr_log[0] !== 29'h1234) begin errors++;
        $display("FAIL arb_write_order got wr cycle %0d addr %h exp after %0d addr 1234",
                 wr_cyc_log[0], wr_addr_log[0], rd_cyc_log[3]); end
      checks++;
      if (ack_cyc_log.size() == 0 || ack_cyc_log[0] <= we_cyc_log[31]) begin errors++;
        $display("FAIL arb_ack_order got ack after last lb write=%0b exp 1", ack_cyc_log.size() != 0); end
    end
  endtask

  task automatic test_busy_stall();
    clear_logs();
    ddr_busy = 1'b1; busy_hold = 10;
    line_num = 8'd0; line_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ddr_read !== 1'b1 || ddr_addr !== BASE || ddr_busy !== 1'b1) begin errors++;
        $display("FAIL stall_hold%0d got rd=%0b addr=%h busy=%0b exp 1 %h 1", i, ddr_read, ddr_addr,
                 ddr_busy, BASE); end
    end
    for (int i = 0; i < 200 && fb_fall_cyc < 0; i++) tick();
    checks++;
    if (rd_addr_log.size() != 4) begin errors++;
      $display("FAIL stall_rd_count got %0d exp 4", rd_addr_log.size()); end
    else begin
      checks++;
      if (rd_addr_log[0] !== BASE || rd_addr_log[1] !== BASE + 29'd8) begin errors++;
        $display("FAIL stall_single_accept got %h %h exp %h %h", rd_addr_log[0], rd_addr_log[1],
                 BASE, BASE + 29'd8); end
    end
    checks++; if (we_addr_log.size() != 32 || we_addr_log[0] !== 6'd0) begin errors++;
      $display("FAIL stall_we got count %0d exp 32 from bank 0", we_addr_log.size()); end
  endtask

  task automatic test_overrun();
    logic [28:0] exp_rd [6];
    logic [15:0] exp_cnt;
`ifdef FETCH_STATS_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    exp_rd = '{BASE + 29'd64, BASE + 29'd72, BASE + 29'd96, BASE + 29'd104, BASE + 29'd112, BASE + 29'd120};
    clear_logs();
    line_num = 8'd2; line_start = 1'b1;
    for (int i = 0; i < 100 && rd_addr_log.size() < 2; i++) tick();
    tick(); tick();
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL overrun_before got %0b exp 0", overrun); end
    line_num = 8'd3; line_start = 1'b1;
    tick();
    checks++; if (overrun !== 1'b1 || overrun_cnt !== exp_cnt) begin errors++;
      $display("FAIL overrun_flag got ov=%0b cnt=%0d exp 1 %0d", overrun, overrun_cnt, exp_cnt); end
    for (int i = 0; i < 300 && fb_fall_cyc < 0; i++) tick();
    checks++;
    if (rd_addr_log.size() != 6) begin errors++;
      $display("FAIL overrun_rd_count got %0d exp 6", rd_addr_log.size()); end
    else for (int k = 0; k < 6; k++) begin
      checks++;
      if (rd_addr_log[k] !== exp_rd[k]) begin errors++;
        $display("FAIL overrun_rd%0d got %h exp %h", k, rd_addr_log[k], exp_rd[k]); end
    end
    checks++;
    if (we_addr_log.size() != 48) begin errors++;
      $display("FAIL overrun_we_count got %0d exp 48", we_addr_log.size()); end
    else begin
      checks++;
      if (we_addr_log[15] !== 6'd15 || we_data_log[15] !== pat(BASE + 29'd79)) begin errors++;
        $display("FAIL overrun_old_tail got %0d %h exp 15 %h", we_addr_log[15], we_data_log[15],
                 pat(BASE + 29'd79)); end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (we_addr_log[16 + i] !== 6'(32 + i) || we_data_log[16 + i] !== pat(BASE + 29'(96 + i))) begin
          errors++;
          $display("FAIL overrun_new_we%0d got %0d %h exp %0d %h", i, we_addr_log[16 + i],
                   we_data_log[16 + i], 32 + i, pat(BASE + 29'(96 + i))); end
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    clear_logs();
    line_num = 8'd4; line_start = 1'b1;
    for (int i = 0; i < 100 && rd_addr_log.size() < 1; i++) tick();
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (ddr_read !== 1'b0 || ddr_write !== 1'b0 || host_wr_ack !== 1'b0 || lb_we !== 1'b0) begin
      errors++;
      $display("FAIL midreset_cmd got rd=%0b wr=%0b ack=%0b we=%0b exp 0", ddr_read, ddr_write,
               host_wr_ack, lb_we); end
    checks++; if (fetch_busy !== 1'b0 || overrun !== 1'b0 || overrun_cnt !== 16'd0) begin errors++;
      $display("FAIL midreset_status got fb=%0b ov=%0b cnt=%0d exp 0", fetch_busy, overrun, overrun_cnt); end
    reset = 1'b0;
    clear_logs();
    repeat (12) tick();
    checks++; if (we_addr_log.size() != 0 || rd_addr_log.size() != 0 || fetch_busy !== 1'b0) begin errors++;
      $display("FAIL midreset_stale got we=%0d rd=%0d fb=%0b exp 0 0 0", we_addr_log.size(),
               rd_addr_log.size(), fetch_busy); end
  endtask

  initial begin
    test_reset();
    test_line_fetch();
    test_host_write();
    test_fetch_vs_host();
    test_busy_stall();
    test_overrun();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish exp finish before 200000");
    $fatal(1);
  end
endmodule
